// File: rtl/pg_multi_gen.sv
// Multi-channel pulse/gate generator: per channel a LEVEL gate, a retriggerable
// ONESHOT or a PERIODIC pulse train, all under start/stop control with registered outputs.
module pg_multi_gen #(
    parameter int unsigned CH    = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         start,
    input  logic [CH-1:0]         stop,
    input  logic [2*CH-1:0]       mode,
    input  logic [CNT_W*CH-1:0]   hi_len,
    input  logic [CNT_W*CH-1:0]   lo_len,
    output logic [CH-1:0]         out,
    output logic [CH-1:0]         busy,
    output logic [CH-1:0]         done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    localparam logic [1:0] M_LEVEL    = 2'b00;
    localparam logic [1:0] M_ONESHOT  = 2'b01;
    localparam logic [1:0] M_PERIODIC = 2'b10;
    localparam logic [1:0] M_RSVD     = 2'b11;

    logic [CH-1:0][1:0]       state_q, state_d;
    logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CH-1:0][1:0]       mode_q, mode_d;
    logic [CH-1:0][CNT_W-1:0] hi_q, hi_d;
    logic [CH-1:0][CNT_W-1:0] lo_q, lo_d;
    logic [CH-1:0]            out_q, out_d;
    logic [CH-1:0]            busy_q, busy_d;
    logic [CH-1:0]            done_q, done_d;

    // Counter load value for a phase of len cycles; a zero length behaves as one cycle.
    function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    // Next-state and output logic for all channels.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = '0;
        out_d   = '0;
        busy_d  = '0;

        for (int i = 0; i < int'(CH); i++) begin
            case (state_q[i])
                S_IDLE: begin
                    if (start[i] && !stop[i]) begin
                        state_d[i] = S_HIGH;
                        cnt_d[i]   = reload(hi_len[CNT_W*i +: CNT_W]);
                        hi_d[i]    = hi_len[CNT_W*i +: CNT_W];
                        lo_d[i]    = lo_len[CNT_W*i +: CNT_W];
                        mode_d[i]  = (mode[2*i +: 2] == M_RSVD) ? M_LEVEL : mode[2*i +: 2];
                    end
                end
                S_HIGH: begin
                    if (stop[i]) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else if (mode_q[i] == M_ONESHOT) begin
                        // Retrigger takes precedence over natural expiry.
                        if (start[i]) begin
                            cnt_d[i] = reload(hi_q[i]);
                        end else if (cnt_q[i] == '0) begin
                            state_d[i] = S_IDLE;
                            done_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end
                    end else if (mode_q[i] == M_PERIODIC) begin
                        if (cnt_q[i] == '0) begin
                            state_d[i] = S_LOW;
                            cnt_d[i]   = reload(lo_q[i]);
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end
                    end
                end
                S_LOW: begin
                    if (stop[i]) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == '0) begin
                        state_d[i] = S_HIGH;
                        cnt_d[i]   = reload(hi_q[i]);
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase

            out_d[i]  = (state_d[i] == S_HIGH);
            busy_d[i] = (state_d[i] != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            out_q   <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pg_multi_gen.sv
// Self-checking bench for pg_multi_gen: directed scenarios plus random traffic
// compared against an elapsed-time reference model of each channel.
module tb_pg_multi_gen;

    localparam int unsigned CH    = 4;
    localparam int unsigned CNT_W = 8;

    logic                clk;
    logic                rst;
    logic [CH-1:0]       start, stop;
    logic [2*CH-1:0]     mode;
    logic [CNT_W*CH-1:0] hi_len, lo_len;
    logic [CH-1:0]       out, busy, done;

    pg_multi_gen #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .hi_len(hi_len), .lo_len(lo_len), .out(out), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a channel remembers the edge of its last (re)trigger and
    // derives its output from elapsed edges with plain arithmetic.
    int          edge_n = 0;
    bit          act [CH];
    int          t0  [CH];
    int          mh  [CH];
    int          ml  [CH];
    logic [1:0]  mm  [CH];
    logic [CH-1:0] exp_out, exp_busy, exp_done;

    function automatic int eff_len(input logic [CNT_W-1:0] v);
        return (v == 0) ? 1 : int'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            act[i] = 0; t0[i] = 0; mh[i] = 1; ml[i] = 1; mm[i] = 2'b00;
        end
        exp_out = '0; exp_busy = '0; exp_done = '0;
    endtask

    task automatic model_step();
        edge_n++;
        if (!rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < CH; i++) begin
                exp_done[i] = 1'b0;
                if (stop[i]) begin
                    act[i] = 0;
                end else if (!act[i]) begin
                    if (start[i]) begin
                        act[i] = 1;
                        t0[i]  = edge_n;
                        mm[i]  = (mode[2*i +: 2] == 2'b11) ? 2'b00 : mode[2*i +: 2];
                        mh[i]  = eff_len(hi_len[CNT_W*i +: CNT_W]);
                        ml[i]  = eff_len(lo_len[CNT_W*i +: CNT_W]);
                    end
                end else if (mm[i] == 2'b01) begin
                    if (start[i]) begin
                        t0[i] = edge_n;
                    end else if (edge_n - t0[i] == mh[i]) begin
                        act[i] = 0;
                        exp_done[i] = 1'b1;
                    end
                end
                exp_busy[i] = act[i];
                exp_out[i]  = act[i] && (mm[i] != 2'b10 ||
                              ((edge_n - t0[i]) % (mh[i] + ml[i])) < mh[i]);
            end
        end
    endtask

    // One clock edge, model update, then settle so outputs can be sampled.
    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] md, input int hi, input int lo);
        mode[2*ch +: 2]          = md;
        hi_len[CNT_W*ch +: CNT_W] = CNT_W'(hi);
        lo_len[CNT_W*ch +: CNT_W] = CNT_W'(lo);
    endtask

    task automatic idle_all();
        start = '0; stop = '1;
        advance();
        stop = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = '1; stop = '0; mode = '0; hi_len = '1; lo_len = '1;
        model_reset();
        #1;
        n_checks++;
        if ({out, busy, done} !== '0)
            $display("FAIL reset_async out/busy/done=%b/%b/%b required 0/0/0", out, busy, done);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            advance();
            n_checks++;
            if ({out, busy, done} !== '0)
                $display("FAIL reset_held cyc %0d out/busy/done=%b/%b/%b required 0/0/0", c, out, busy, done);
            else n_pass++;
        end
        rst = 1'b1; start = '0;
        for (int c = 0; c < 3; c++) begin
            advance();
            n_checks++;
            if ({out, busy, done} !== {exp_out, exp_busy, exp_done} || {out, busy, done} !== '0)
                $display("FAIL reset_release cyc %0d out/busy/done=%b/%b/%b required 0/0/0", c, out, busy, done);
            else n_pass++;
        end
    endtask

    task automatic test_level();
        set_ch(0, 2'b00, 1, 1);
        start[0] = 1'b1;
        for (int c = 0; c < 13; c++) begin
            advance();
            start[0] = 1'b0;
            stop[0]  = (c == 9);
            n_checks++;
            if ({out, busy, done} !== {exp_out, exp_busy, exp_done} || (c < 10 && out !== 4'b0001))
                $display("FAIL level cyc %0d out/busy/done=%b/%b/%b required %b/%b/%b",
                         c, out, busy, done, exp_out, exp_busy, exp_done);
            else n_pass++;
        end
        stop = '0;
    endtask

    task automatic test_oneshot();
        int dones;
        dones = 0;
        set_ch(1, 2'b01, 3, 0);
        // First a plain pulse, then one retriggered at its second high cycle.
        for (int run = 0; run < 2; run++) begin
            start[1] = 1'b1;
            for (int c = 0; c < 8; c++) begin
                advance();
                start[1] = (run == 1 && c == 1);
                if (done[1]) dones++;
                n_checks++;
                if ({out, busy, done} !== {exp_out, exp_busy, exp_done})
                    $display("FAIL oneshot run %0d cyc %0d out/busy/done=%b/%b/%b required %b/%b/%b",
                             run, c, out, busy, done, exp_out, exp_busy, exp_done);
                else n_pass++;
            end
        end
        n_checks++;
        if (dones !== 2)
            $display("FAIL oneshot_done_count got %0d required 2", dones);
        else n_pass++;
    endtask

    task automatic test_periodic();
        int dones;
        dones = 0;
        set_ch(2, 2'b10, 2, 3);
        start[2] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            advance();
            start[2] = (c == 6);
            stop[2]  = (c == 12);
            if (done[2]) dones++;
            n_checks++;
            if ({out, busy, done} !== {exp_out, exp_busy, exp_done})
                $display("FAIL periodic cyc %0d out/busy/done=%b/%b/%b required %b/%b/%b",
                         c, out, busy, done, exp_out, exp_busy, exp_done);
            else n_pass++;
        end
        stop = '0;
        n_checks++;
        if (dones !== 0)
            $display("FAIL periodic_done got %0d pulses required 0", dones);
        else n_pass++;
    endtask

    task automatic test_edge();
        // Zero-length oneshot, start+stop together in idle, stop on final oneshot cycle.
        set_ch(3, 2'b01, 0, 0);
        set_ch(0, 2'b10, 2, 2);
        set_ch(1, 2'b01, 2, 0);
        start = 4'b1011; stop = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            advance();
            start = '0;
            stop  = (c == 1) ? 4'b0010 : 4'b0000;
            n_checks++;
            if ({out, busy, done} !== {exp_out, exp_busy, exp_done} ||
                (c == 1 && done !== 4'b1000) || (c == 2 && done !== 4'b0000))
                $display("FAIL edge cyc %0d out/busy/done=%b/%b/%b required %b/%b/%b",
                         c, out, busy, done, exp_out, exp_busy, exp_done);
            else n_pass++;
        end
    endtask

    task automatic test_concurrency();
        set_ch(0, 2'b00, 5, 5);
        set_ch(1, 2'b01, 4, 0);
        set_ch(2, 2'b10, 1, 2);
        set_ch(3, 2'b11, 3, 3);
        start = '1;
        for (int c = 0; c < 3; c++) begin
            advance();
            start = '0;
            n_checks++;
            if ({out, busy, done} !== {exp_out, exp_busy, exp_done})
                $display("FAIL concurrent cyc %0d out/busy/done=%b/%b/%b required %b/%b/%b",
                         c, out, busy, done, exp_out, exp_busy, exp_done);
            else n_pass++;
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({out, busy, done} !== '0)
            $display("FAIL midreset out/busy/done=%b/%b/%b required 0/0/0", out, busy, done);
        else n_pass++;
        advance();
        advance();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            advance();
            n_checks++;
            if ({out, busy, done} !== '0)
                $display("FAIL post_reset cyc %0d out/busy/done=%b/%b/%b required 0/0/0", c, out, busy, done);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < CH; i++) begin
                start[i] = ($urandom_range(0, 5) == 0);
                stop[i]  = ($urandom_range(0, 15) == 0);
                set_ch(i, 2'($urandom_range(0, 3)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
            end
            advance();
            n_checks++;
            if ({out, busy, done} !== {exp_out, exp_busy, exp_done})
                $display("FAIL random cyc %0d out/busy/done=%b/%b/%b required %b/%b/%b",
                         c, out, busy, done, exp_out, exp_busy, exp_done);
            else n_pass++;
        end
        start = '0; stop = '0;
    endtask

    initial begin
        test_reset();
        test_level();
        idle_all();
        test_oneshot();
        idle_all();
        test_periodic();
        idle_all();
        test_edge();
        idle_all();
        test_concurrency();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pg_multi_gen.md
Name: pg_multi_gen

Overview:
- Parametrised multi-channel pulse/gate generator; successor to the single-channel start/stop gate generator used for FFT frame gating.
- Each channel independently produces a level gate, a programmable-width one-shot, or a periodic pulse train, under start/stop control.
- Sits between the control sequencer and the FFT/datapath blocks; outputs are registered, glitch-free enables.

Parameters:
CH, 4, number of independent channels
CNT_W, 8, width of the high/low length counters (lengths 1..2^CNT_W-1 cycles)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
start  input  CH  per-channel start request, sampled each clk edge
stop  input  CH  per-channel stop request, sampled each clk edge
mode  input  2*CH  per-channel mode, channel i at [2i+1:2i]: 00 LEVEL, 01 ONESHOT, 10 PERIODIC, 11 reserved (treated as LEVEL)
hi_len  input  CNT_W*CH  per-channel high time in cycles, channel i at [CNT_W*(i+1)-1:CNT_W*i]
lo_len  input  CNT_W*CH  per-channel low time in cycles (PERIODIC only), same packing
out  output  CH  per-channel gate/pulse output, registered
busy  output  CH  per-channel active flag (state != IDLE), registered
done  output  CH  per-channel one-cycle pulse on natural ONESHOT completion

Behaviour:
- Reset (rst=0, asynchronous): all channels to IDLE; out=0, busy=0, done=0, counters=0, latched mode/lengths=0.
- Channels fully independent; one FSM + CNT_W counter + latched mode/hi/lo per channel.
- States: IDLE, HIGH, LOW. out=1 only in HIGH. busy=1 in HIGH or LOW.
- mode, hi_len, lo_len latched at the edge that accepts start; changes while busy have no effect until next accepted start.
- Length 0 treated as 1.
- Latency: start sampled at edge k -> out=1 and busy=1 after edge k (visible cycle k+1).
- IDLE: start=1 and stop=0 -> HIGH, cnt = hi_len-1. Otherwise stay IDLE.
- LEVEL: HIGH held until stop; no counting.
- ONESHOT: in HIGH, cnt==0 -> IDLE with done=1 for exactly one cycle (coincident with out falling); else cnt decrements. Output high for exactly hi_len cycles.
- PERIODIC: HIGH cnt==0 -> LOW, cnt = lo_len-1; LOW cnt==0 -> HIGH, cnt = hi_len-1. Period = hi_len+lo_len cycles, repeats until stop.
- stop=1 in any state -> IDLE at next edge, out=0, done=0; stop has priority over start and over counter expiry in the same cycle.
- start while busy: ONESHOT retriggers (cnt reloaded to latched hi_len-1, stays HIGH, no done); LEVEL and PERIODIC ignore it.
- start and stop simultaneously in IDLE: stays IDLE.
- ONESHOT expiry with start in same cycle: retrigger wins, no done, stays HIGH.
- done never asserted in LEVEL or PERIODIC modes.
- Asynchronous reset mid-operation: immediate return to reset values; no done emitted.

Test Plan:
- Reset: rst=0 with start=4'hF -> out=0, busy=0, done=0 throughout; release rst, no start -> all remain 0.
- LEVEL ch0: start[0] pulse at cycle 5, stop[0] at cycle 15 -> out[0]=1 cycles 6..15, 0 from cycle 16; other channels 0.
- ONESHOT ch1 hi_len=3: start at cycle 2 -> out[1]=1 cycles 3,4,5; done[1]=1 on cycle 6 only; busy[1] falls with out; retrigger at cycle 4 extends high through cycle 7 with single done on cycle 8.
- PERIODIC ch2 hi_len=2, lo_len=3: start at cycle 0 -> out[2] pattern 1,1,0,0,0 repeating from cycle 1; stop mid-LOW -> out stays 0, busy=0 next cycle; done[2] never 1.
- Priority/edge: hi_len=0 ONESHOT -> 1-cycle pulse; start+stop same cycle in IDLE -> no activity; stop on ONESHOT final cycle -> no done.
- Concurrency/reset: all 4 channels started same cycle in different modes -> independent correct waveforms; assert rst mid-pulse -> all outputs 0 immediately, no done.
